platform_sequencer: RTL and testbench

Controller for the startup platform animation. Generates `start_game` and the 4-bit platform-disable mask `ctl` consumed by the horizontal-platform renderer, removing platforms one at a time on frame boundaries so the incline-platform renderer can take their place. Sits in the top-level game logic, clocked with the VGA pipeline, and watches the VGA timing stream only to count frames.

---
 rtl/animation_pkg.sv | 17 +
 rtl/vga_if.sv | 14 +
 rtl/vblnk_edge.sv | 22 ++
 rtl/platform_sequencer.sv | 107 ++++++++++
 tb/tb_platform_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/animation_pkg.sv
// rtl/animation_pkg.sv - shared types and constants for frame-based platform animations
package animation_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DROP = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic [3:0] CTL_NONE = 4'h0;
  localparam logic [3:0] CTL_ALL  = 4'hF;

  localparam int FRAMES_HOLD_DEF = 60;
  localparam int FRAMES_STEP_DEF = 30;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing stream bundle shared by the video pipeline stages
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/vblnk_edge.sv
// rtl/vblnk_edge.sv - rising-edge detector on vertical blanking, one tick per frame
module vblnk_edge (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
    end
  end

  // Combinational so the tick lands in the same cycle vblnk rises.
  assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/platform_sequencer.sv
// rtl/platform_sequencer.sv - startup animation: holds all platforms, then removes
// them one by one (bit 3 first) on frame boundaries
module platform_sequencer
  import animation_pkg::*;
#(
  parameter int FRAMES_HOLD = FRAMES_HOLD_DEF,
  parameter int FRAMES_STEP = FRAMES_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       restart,
  vga_if.in          in,
  output logic       start_game,
  output logic [3:0] ctl,
  output logic       anim_done
);

  localparam logic [7:0] HOLD8 = 8'(FRAMES_HOLD);
  localparam logic [7:0] STEP8 = 8'(FRAMES_STEP);

  seq_state_t state, state_n;
  logic [7:0] fcnt, fcnt_n, fcnt_inc;
  logic [3:0] ctl_n, ctl_shift;
  logic       tick;

  vblnk_edge u_vblnk_edge (
    .clk   (clk),
    .rst   (rst),
    .vblnk (in.vblnk),
    .tick  (tick)
  );

  assign fcnt_inc  = fcnt + 8'd1;
  assign ctl_shift = {1'b1, ctl[3:1]};

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    ctl_n   = ctl;
    if (restart) begin
      state_n = IDLE;
      fcnt_n  = 8'd0;
      ctl_n   = CTL_NONE;
    end else begin
      case (state)
        IDLE: begin
          ctl_n = CTL_NONE;
          if (start) begin
            state_n = SHOW;
            fcnt_n  = 8'd0;
          end
        end
        SHOW: begin
          if (tick) begin
            if (fcnt_inc == HOLD8) begin
              state_n = DROP;
              fcnt_n  = 8'd0;
              ctl_n   = 4'b1000;
            end else begin
              fcnt_n = fcnt_inc;
            end
          end
        end
        DROP: begin
          if (tick) begin
            if (fcnt_inc == STEP8) begin
              fcnt_n = 8'd0;
              ctl_n  = ctl_shift;
              if (ctl_shift == CTL_ALL) begin
                state_n = DONE;
              end
            end else begin
              fcnt_n = fcnt_inc;
            end
          end
        end
        DONE: begin
          ctl_n = CTL_ALL;
        end
        default: begin
          state_n = IDLE;
          fcnt_n  = 8'd0;
          ctl_n   = CTL_NONE;
        end
      endcase
    end
  end

  // Flags derive from the next state so every output stays a plain register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fcnt       <= 8'd0;
      ctl        <= CTL_NONE;
      start_game <= 1'b0;
      anim_done  <= 1'b0;
    end else begin
      state      <= state_n;
      fcnt       <= fcnt_n;
      ctl        <= ctl_n;
      start_game <= (state_n != IDLE);
      anim_done  <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_platform_sequencer.sv
// tb/tb_platform_sequencer.sv - randomized and directed checks of platform_sequencer
// against a tick-count model, three parameter sets in parallel
module tb_platform_sequencer;

  logic clk;
  logic rst;
  logic start;
  logic restart;

  logic       sg_a, sg_b, sg_c;
  logic       ad_a, ad_b, ad_c;
  logic [3:0] ctl_a, ctl_b, ctl_c;

  int tests;
  int fails;

  vga_if vga ();

  platform_sequencer #(.FRAMES_HOLD(2), .FRAMES_STEP(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .restart(restart), .in(vga),
    .start_game(sg_a), .ctl(ctl_a), .anim_done(ad_a)
  );

  platform_sequencer #(.FRAMES_HOLD(255), .FRAMES_STEP(255)) dut_b (
    .clk(clk), .rst(rst), .start(start), .restart(restart), .in(vga),
    .start_game(sg_b), .ctl(ctl_b), .anim_done(ad_b)
  );

  platform_sequencer #(.FRAMES_HOLD(5), .FRAMES_STEP(3)) dut_c (
    .clk(clk), .rst(rst), .start(start), .restart(restart), .in(vga),
    .start_game(sg_c), .ctl(ctl_c), .anim_done(ad_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: a run is just the number of counted ticks since start; the mask follows
  // from how many removals that many ticks has paid for.
  int  m_hold [3] = '{2, 255, 5};
  int  m_step [3] = '{1, 255, 3};
  bit  m_run  [3];
  int  m_ticks[3];
  bit  m_prev;

  function automatic logic [3:0] exp_ctl(input int t, input int h, input int s);
    int d;
    logic [7:0] m;
    if (t < h) return 4'h0;
    d = 1 + (t - h) / s;
    if (d > 4) d = 4;
    m = 8'hF0 >> d;
    return m[3:0];
  endfunction

  always @(posedge clk) begin
    bit tk;
    logic [3:0] ec;
    logic [3:0] gc;
    logic gs, ga;
    tk = vga.vblnk && !m_prev;
    for (int i = 0; i < 3; i++) begin
      if (rst || restart) begin
        m_run[i]   = 1'b0;
        m_ticks[i] = 0;
      end else if (!m_run[i] && start) begin
        m_run[i]   = 1'b1;
        m_ticks[i] = 0;
      end else if (m_run[i] && tk && m_ticks[i] < m_hold[i] + 3 * m_step[i]) begin
        m_ticks[i]++;
      end
    end
    m_prev = rst ? 1'b0 : vga.vblnk;
    #1;
    for (int i = 0; i < 3; i++) begin
      ec = m_run[i] ? exp_ctl(m_ticks[i], m_hold[i], m_step[i]) : 4'h0;
      case (i)
        0: begin gc = ctl_a; gs = sg_a; ga = ad_a; end
        1: begin gc = ctl_b; gs = sg_b; ga = ad_b; end
        default: begin gc = ctl_c; gs = sg_c; ga = ad_c; end
      endcase
      check($sformatf("model_dut%0d {sg,ctl,done}", i), int'({gs, gc, ga}),
            int'({m_run[i], ec, (m_run[i] && ec == 4'hF)}));
    end
  end

  task automatic frame(input int low);
    vga.vblnk = 1'b1;
    @(negedge clk);
    vga.vblnk = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic check_a(input string name, input logic s, input logic [3:0] c, input logic d);
    check({name, "_sg"}, int'(sg_a), int'(s));
    check({name, "_ctl"}, int'(ctl_a), int'(c));
    check({name, "_done"}, int'(ad_a), int'(d));
  endtask

  initial begin
    logic [3:0] seq_a [5];
    seq_a = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF};
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    restart = 1'b0;
    vga.vblnk = 1'b0;
    vga.hblnk = 1'b0;
    vga.hsync = 1'b0;
    vga.vsync = 1'b0;
    vga.hcount = '0;
    vga.vcount = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_a("reset", 1'b0, 4'h0, 1'b0);

    repeat (3) frame(3);
    check_a("idle3", 1'b0, 4'h0, 1'b0);

    pulse_start();
    check_a("start_next", 1'b1, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      frame(2);
      check($sformatf("run_ctl_tick%0d", k + 1), int'(ctl_a), int'(seq_a[k]));
      check($sformatf("run_done_tick%0d", k + 1), int'(ad_a), (k == 4) ? 1 : 0);
    end
    pulse_restart();
    check_a("restart_done", 1'b0, 4'h0, 1'b0);

    // start coincident with a frame tick: that tick does not count
    start = 1'b1;
    vga.vblnk = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vga.vblnk = 1'b0;
    repeat (2) @(negedge clk);
    check_a("coinc_tick0", 1'b1, 4'h0, 1'b0);
    frame(2);
    check_a("coinc_tick1", 1'b1, 4'h0, 1'b0);
    frame(2);
    check_a("coinc_tick2", 1'b1, 4'h8, 1'b0);
    frame(2);
    check_a("coinc_tick3", 1'b1, 4'hC, 1'b0);
    pulse_restart();
    check_a("restart_mid_drop", 1'b0, 4'h0, 1'b0);

    start = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    start = 1'b0;
    restart = 1'b0;
    check_a("start_and_restart", 1'b0, 4'h0, 1'b0);

    pulse_start();
    repeat (3) frame(2);
    pulse_start();
    check_a("start_in_drop", 1'b1, 4'hC, 1'b0);
    frame(2);
    check_a("drop_after_start", 1'b1, 4'hE, 1'b0);
    frame(2);
    pulse_start();
    check_a("start_in_done", 1'b1, 4'hF, 1'b1);

    pulse_restart();
    pulse_start();
    for (int k = 1; k <= 1020; k++) begin
      frame(2);
      if (k == 254) check("long_ctl_254", int'(ctl_b), 0);
      if (k == 255) check("long_ctl_255", int'(ctl_b), 8);
      if (k == 510) check("long_ctl_510", int'(ctl_b), 12);
      if (k == 1019) check("long_done_1019", int'(ad_b), 0);
      if (k == 1020) begin
        check("long_done_1020", int'(ad_b), 1);
        check("long_ctl_1020", int'(ctl_b), 15);
      end
    end

    for (int n = 0; n < 4000; n++) begin
      vga.vblnk = ($urandom_range(0, 2) == 0);
      start     = ($urandom_range(0, 15) == 0);
      restart   = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    vga.vblnk = 1'b0;
    start = 1'b0;
    restart = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
